alu_bist: RTL and testbench
===========================

# alu_bist

Self-checking built-in stimulus generator for the 8-bit RISC `ALUnit`. It drives the ALU operand and control inputs (`A`, `B`, `ALU_ctrl`) and samples its outputs (`ALU_o`, `cout`, `zero`). Each sampled result is compared against a golden model, and the block keeps correct/wrong tallies. It sits beside the ALU in the datapath and gives silicon and FPGA builds a run-time ALU self-test.

## Interface
- `W`, default 8: operand width; legal range 1..8. Operands use the low `W` bits of the LFSR bytes.
- `NUM_VECTORS`, default 1000: number of vectors per run; legal range 1..65535.
- `SEED`, default 24'h5A_A5C3: LFSR seed; a value of 0 is replaced by 24'h000001.
- `SETTLE_CYCLES`, default 1: number of cycles between driving the ALU and sampling it; legal range 1..15.
- `clk` in 1: clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `start` in 1: single-cycle run request.
- `busy` out 1: a run is in progress.
- `done` out 1: the run is complete; held until the next start or reset.
- `pass` out 1: valid while `done`; 1 iff `wrong_cnt` == 0.
- `a_o`, `b_o` out W: ALU operands.
- `alu_ctrl_o` out 4: ALU opcode.
- `alu_res_i` in W: ALU result.
- `alu_cout_i` in 1: ALU carry out.
- `alu_zero_i` in 1: ALU zero flag.
- `correct_cnt`, `wrong_cnt` out 16: vector tallies; saturate at 16'hFFFF.
- `first_fail_idx` out 16: index of the first failing vector; 16'hFFFF if no vector has failed.

## Operation
- FSM states and transitions:
  - IDLE→DRIVE on `start`.
  - DRIVE→SETTLE.
  - SETTLE→CHECK after `SETTLE_CYCLES` cycles.
  - CHECK→DRIVE, or CHECK→DONE when `vec_idx` == `NUM_VECTORS`-1.
  - DONE→DRIVE on `start`.
- Leaving IDLE or DONE on `start` clears the counters, `vec_idx` and `done`, and sets `first_fail_idx` to 16'hFFFF. The LFSR is not reseeded; only reset reseeds it.
- LFSR: 24-bit Galois, mask 24'hE10000, shifting right. It advances once in each CHECK.
- In DRIVE the current LFSR value is decoded into the vector:
  - `a_o` = lfsr[W-1:0]
  - `b_o` = lfsr[8+W-1:8]
  - op index = lfsr[18:16]; values 6 and 7 fold to 0 and 1.
- Op index maps to `alu_ctrl_o` and the golden check:
  - 0 → 0 (AND): `alu_res_i` == a&b.
  - 1 → 1 (OR): `alu_res_i` == a|b.
  - 2 → 2 (ADD): {`alu_cout_i`,`alu_res_i`} == a+b, computed at W+1 bits.
  - 3 → 6 (SUB): `alu_res_i` == (a-b) mod 2^W.
  - 4 → 7 (SLT): `alu_res_i` == (a<b ? 1 : 0), unsigned compare.
  - 5 → 12 (NOR): `alu_res_i` == ~(a|b).
- `cout` is checked only for ADD.
- In CHECK exactly one of `correct_cnt` or `wrong_cnt` increments. On the first wrong vector, `first_fail_idx` captures `vec_idx`.
- `start` is ignored in DRIVE, SETTLE and CHECK.

## Timing
- Every output is registered.
- Reset values:
  - state IDLE
  - `a_o`/`b_o`/`alu_ctrl_o` = 0
  - `busy`/`done`/`pass` = 0
  - counters 0
  - `first_fail_idx` 16'hFFFF
  - LFSR = `SEED`.
- If `start` is sampled high at edge t, `busy`=1 and the first vector is on `a_o`/`b_o`/`alu_ctrl_o` after edge t+1.
- Operands stay stable from DRIVE through CHECK. The ALU inputs are sampled in the CHECK cycle, i.e. `SETTLE_CYCLES`+1 cycles after the drive.
- Each vector takes `SETTLE_CYCLES`+2 cycles.
- `done`=1 and `busy`=0 begin on the edge that leaves the last CHECK. The run length is `NUM_VECTORS`×(`SETTLE_CYCLES`+2) cycles.
- Reset asserted mid-run: the next edge restores all reset values; any partial vector is discarded.
- If `start` and `rst_n`=0 occur in the same cycle, reset wins.

## Configuration
- `ALU_BIST_ZERO_CHK_EN`:
  - Defined: every opcode additionally requires `alu_zero_i` == (expected result == 0); a mismatch counts the vector as wrong.
  - Undefined: `alu_zero_i` is ignored; the port remains for interface stability.

## Structure
- Package `alu_pkg` holds:
  - the `ALU_AND`/`OR`/`ADD`/`SUB`/`SLT`/`NOR` opcode constants (0,1,2,6,7,12);
  - the `alu_op_e` typedef;
  - the golden-model function `alu_expect(a,b,ctrl)`, returning {cout,res}.
- The FSM state enum is local.
- One sub-module: `lfsr24`, with ports `clk`, `rst_n`, `load`, `seed`, `adv`, `q`.

## Test plan
- Run 1 (correct ALU): behavioural correct ALU, defaults, pulse `start`. Expect:
  - `done` after exactly 3000 cycles;
  - `correct_cnt`=1000, `wrong_cnt`=0, `pass`=1, `first_fail_idx`=16'hFFFF.
- Run 2 (faulty SUB): ALU returns a+b for SUB. Expect:
  - `pass`=0;
  - `correct_cnt`+`wrong_cnt`=1000;
  - `first_fail_idx` equals the index of the first SUB vector, per the reference-model LFSR.
- Run 3 (SEED=0): first driven vector is `a_o`=8'h01, `b_o`=8'h00, `alu_ctrl_o`=0.
- Run 4 (start while busy): `start` pulsed at vector 10 and vector 500. Expect no restart; final counts match Run 1.
- Run 5 (reset mid-run): `rst_n` low for one cycle at vector 500. Expect:
  - next edge: `busy`=0, counts 0;
  - after restart, the first 5 vectors are identical to Run 1.
- Run 6 (zero flag): `zero` stuck at 0. With `ALU_BIST_ZERO_CHK_EN` defined, `pass`=0 iff any expected result is 0. Without the macro, `pass`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU self-test block.
//   - alu_op_e     : ALU opcode encoding (AND/OR/ADD/SUB/SLT/NOR)
//   - LFSR_MASK    : Galois feedback mask for the 24-bit stimulus LFSR
//   - alu_expect() : golden ALU model, returns {cout, res[7:0]} for a w-bit ALU
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_op_e;

    localparam logic [23:0] LFSR_MASK = 24'hE10000;

    // Operands are zero-extended w-bit values; result bits above w are forced to 0.
    // cout is only meaningful for ALU_ADD and is taken from bit w of the sum.
    function automatic logic [8:0] alu_expect(input logic [7:0]  a,
                                              input logic [7:0]  b,
                                              input alu_op_e     ctrl,
                                              input int unsigned w);
        logic [8:0] mask;
        logic [8:0] sum;
        logic [8:0] r;
        logic       cout;
        mask = 9'((1 << w) - 1);
        sum  = {1'b0, a} + {1'b0, b};
        cout = 1'b0;
        case (ctrl)
            ALU_AND: r = {1'b0, a & b};
            ALU_OR:  r = {1'b0, a | b};
            ALU_ADD: begin
                r    = sum;
                cout = |(sum & ~mask);
            end
            ALU_SUB: r = {1'b0, a} - {1'b0, b};
            ALU_SLT: r = {8'b0, (a < b)};
            ALU_NOR: r = {1'b0, ~(a | b)};
            default: r = 9'd0;
        endcase
        return {cout, r[7:0] & mask[7:0]};
    endfunction

endpackage

// File: rtl/lfsr24.sv
// lfsr24: 24-bit right-shifting Galois LFSR (mask from alu_pkg::LFSR_MASK).
//   clk   : clock
//   rst_n : synchronous active-low reset, loads seed
//   load  : synchronous reload from seed
//   seed  : reload value (must be non-zero)
//   adv   : advance one step
//   q     : current LFSR state
module lfsr24
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [23:0] seed,
    input  logic        adv,
    output logic [23:0] q
);

    logic [23:0] q_next;

    always_comb begin
        q_next = q >> 1;
        if (q[0]) begin
            q_next = q_next ^ LFSR_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            q <= seed;
        end else if (adv) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/alu_bist.sv
// alu_bist: run-time ALU self-test. Drives pseudo-random vectors into the ALU, samples its
// result after a settle delay, checks it against alu_pkg::alu_expect and keeps tallies.
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : run request (honoured in idle/done only)
//   busy, done, pass      : run status; pass valid while done
//   a_o, b_o, alu_ctrl_o  : ALU operands and opcode
//   alu_res_i, alu_cout_i, alu_zero_i : ALU outputs
//   correct_cnt, wrong_cnt: saturating vector tallies
//   first_fail_idx        : index of first failing vector, 16'hFFFF if none
// Optional macro ALU_BIST_ZERO_CHK_EN: also check alu_zero_i against the expected result.
module alu_bist
    import alu_pkg::*;
#(
    parameter int unsigned W             = 8,
    parameter int unsigned NUM_VECTORS   = 1000,
    parameter logic [23:0] SEED          = 24'h5A_A5C3,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic [3:0]   alu_ctrl_o,
    input  logic [W-1:0] alu_res_i,
    input  logic         alu_cout_i,
    input  logic         alu_zero_i,
    output logic [15:0]  correct_cnt,
    output logic [15:0]  wrong_cnt,
    output logic [15:0]  first_fail_idx
);

    localparam logic [23:0] SEED_EFF    = (SEED == 24'd0) ? 24'h000001 : SEED;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  settle_q, settle_d;
    logic [15:0] vec_idx_q, vec_idx_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    alu_op_e     ctrl_q, ctrl_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0] correct_q, correct_d, wrong_q, wrong_d, ffail_q, ffail_d;
    logic [23:0] lfsr_q;
    logic        lfsr_adv;
    logic [8:0]  exp_res;
    logic        zero_ok, vec_ok;
    logic        unused_bits;

    // Op index 6 and 7 fold onto AND and OR.
    function automatic alu_op_e op_decode(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd6: return ALU_AND;
            3'd1, 3'd7: return ALU_OR;
            3'd2:       return ALU_ADD;
            3'd3:       return ALU_SUB;
            3'd4:       return ALU_SLT;
            default:    return ALU_NOR;
        endcase
    endfunction

    // The stimulus sequence continues across runs; only reset reseeds it.
    lfsr24 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (1'b0),
        .seed  (SEED_EFF),
        .adv   (lfsr_adv),
        .q     (lfsr_q)
    );

    assign exp_res = alu_expect(8'(a_q), 8'(b_q), ctrl_q, W);

`ifdef ALU_BIST_ZERO_CHK_EN
    assign zero_ok     = (alu_zero_i == (exp_res[W-1:0] == '0));
    assign unused_bits = ^{lfsr_q, exp_res};
`else
    assign zero_ok     = 1'b1;
    assign unused_bits = ^{lfsr_q, exp_res, alu_zero_i};
`endif

    assign vec_ok = (alu_res_i == exp_res[W-1:0]) &&
                    ((ctrl_q != ALU_ADD) || (alu_cout_i == exp_res[8])) &&
                    zero_ok;

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        vec_idx_d = vec_idx_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        ffail_d   = ffail_q;
        lfsr_adv  = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StDrive;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    vec_idx_d = 16'd0;
                    correct_d = 16'd0;
                    wrong_d   = 16'd0;
                    ffail_d   = 16'hFFFF;
                end
            end
            StDrive: begin
                a_d      = lfsr_q[W-1:0];
                b_d      = lfsr_q[8 +: W];
                ctrl_d   = op_decode(lfsr_q[18:16]);
                settle_d = 4'd0;
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = StCheck;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            StCheck: begin
                lfsr_adv = 1'b1;
                if (vec_ok) begin
                    if (correct_q != 16'hFFFF) correct_d = correct_q + 16'd1;
                end else begin
                    if (wrong_q == 16'd0) ffail_d = vec_idx_q;
                    if (wrong_q != 16'hFFFF) wrong_d = wrong_q + 16'd1;
                end
                if (vec_idx_q == LAST_IDX) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = vec_ok && (wrong_q == 16'd0);
                end else begin
                    vec_idx_d = vec_idx_q + 16'd1;
                    state_d   = StDrive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            settle_q  <= 4'd0;
            vec_idx_q <= 16'd0;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= ALU_AND;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            correct_q <= 16'd0;
            wrong_q   <= 16'd0;
            ffail_q   <= 16'hFFFF;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            vec_idx_q <= vec_idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctrl_q    <= ctrl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            ffail_q   <= ffail_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign a_o            = a_q;
    assign b_o            = b_q;
    assign alu_ctrl_o     = ctrl_q;
    assign correct_cnt    = correct_q;
    assign wrong_cnt      = wrong_q;
    assign first_fail_idx = ffail_q;

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: directed run sequence around alu_bist with a behavioural ALU (fault-injectable)
// and a reference model of the vector stream and the expected tallies.
// Honours ALU_BIST_ZERO_CHK_EN in the same way as the design.
module tb_alu_bist;

    localparam logic [23:0] SEED = 24'h5A_A5C3;
    localparam int          VC   = 3;     // cycles per vector at SETTLE_CYCLES = 1
    localparam int          NV   = 1000;

    logic        clk, rst_n, start, start0;
    logic        busy, done, pass;
    logic [7:0]  a_o, b_o, alu_res;
    logic [3:0]  alu_ctrl_o;
    logic        alu_cout, alu_zero;
    logic [15:0] correct_cnt, wrong_cnt, first_fail_idx;

    logic        busy0, done0, pass0;
    logic [7:0]  a0, b0;
    logic [3:0]  c0;
    logic [15:0] cc0, wc0, ff0;

    logic        fault_sub, zero_stuck;
    logic [23:0] m_lfsr;
    int          n_assert, n_fail;

    alu_bist u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .a_o            (a_o),
        .b_o            (b_o),
        .alu_ctrl_o     (alu_ctrl_o),
        .alu_res_i      (alu_res),
        .alu_cout_i     (alu_cout),
        .alu_zero_i     (alu_zero),
        .correct_cnt    (correct_cnt),
        .wrong_cnt      (wrong_cnt),
        .first_fail_idx (first_fail_idx)
    );

    alu_bist #(.SEED(24'h0)) u_dut_s0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start0),
        .busy           (busy0),
        .done           (done0),
        .pass           (pass0),
        .a_o            (a0),
        .b_o            (b0),
        .alu_ctrl_o     (c0),
        .alu_res_i      (8'h00),
        .alu_cout_i     (1'b0),
        .alu_zero_i     (1'b0),
        .correct_cnt    (cc0),
        .wrong_cnt      (wc0),
        .first_fail_idx (ff0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU in plain integer arithmetic; fault makes SUB return a+b.
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] ctrl, input logic fault);
        int ai, bi, r, c;
        ai = a;
        bi = b;
        c  = 0;
        case (ctrl)
            4'd0:  r = ai & bi;
            4'd1:  r = ai | bi;
            4'd2:  begin r = ai + bi; c = (r > 255) ? 1 : 0; r = r % 256; end
            4'd6:  r = fault ? (ai + bi) % 256 : (ai - bi + 256) % 256;
            4'd7:  r = (ai < bi) ? 1 : 0;
            4'd12: r = 255 - (ai | bi);
            default: r = 0;
        endcase
        return 9'(c * 256 + r);
    endfunction

    function automatic logic [3:0] op_ctrl(input int idx);
        case (idx)
            0: return 4'd0;
            1: return 4'd1;
            2: return 4'd2;
            3: return 4'd6;
            4: return 4'd7;
            default: return 4'd12;
        endcase
    endfunction

    function automatic logic [23:0] lfsr_next(input logic [23:0] s);
        return s[0] ? ((s >> 1) ^ 24'hE10000) : (s >> 1);
    endfunction

    always_comb begin
        {alu_cout, alu_res} = ref_alu(a_o, b_o, alu_ctrl_o, fault_sub);
        alu_zero = zero_stuck ? 1'b0 : (alu_res == 8'h00);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1'b1));
    endtask

    // Follows one run from the negedge after the start edge. Checks every driven vector
    // against the model stream and the final tallies against the model scoreboard.
    // Optionally pulses start at two vector indices, or applies reset at rst_v and returns.
    task automatic run(input int start_v1, input int start_v2, input int rst_v);
        int ec, ew, ef, cyc, vi;
        logic [7:0] ea, eb;
        logic [3:0] ectrl;
        logic [8:0] g, d;
        logic       dz, ok;
        ec = 0; ew = 0; ef = 16'hFFFF; cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if ((cyc % VC) == 1 && (cyc / VC) < NV) begin
                vi    = cyc / VC;
                ea    = m_lfsr[7:0];
                eb    = m_lfsr[15:8];
                ectrl = op_ctrl(int'(m_lfsr[18:16]) % 6);
                check($sformatf("vector%0d", vi), 64'({a_o, b_o, alu_ctrl_o}),
                      64'({ea, eb, ectrl}));
                g  = ref_alu(ea, eb, ectrl, 1'b0);
                d  = ref_alu(ea, eb, ectrl, fault_sub);
                dz = zero_stuck ? 1'b0 : (d[7:0] == 8'h00);
                ok = (d[7:0] == g[7:0]) && (ectrl != 4'd2 || d[8] == g[8]);
`ifdef ALU_BIST_ZERO_CHK_EN
                ok = ok && (dz == (g[7:0] == 8'h00));
`else
                if (dz) ok = ok;
`endif
                if (ok) ec++;
                else begin
                    if (ew == 0) ef = vi;
                    ew++;
                end
                m_lfsr = lfsr_next(m_lfsr);
                if (vi == start_v1 || vi == start_v2) start = 1'b1;
                if (vi == rst_v) begin
                    // start in the same cycle as reset: reset must win
                    rst_n = 1'b0;
                    start = 1'b1;
                    @(negedge clk);
                    rst_n = 1'b1;
                    start = 1'b0;
                    check("rst_busy", 64'(busy), 64'(1'b0));
                    check("rst_done", 64'(done), 64'(1'b0));
                    check("rst_counts", 64'({correct_cnt, wrong_cnt}), 64'(0));
                    check("rst_ffail", 64'(first_fail_idx), 64'(16'hFFFF));
                    check("rst_vec", 64'({a_o, b_o, alu_ctrl_o}), 64'(0));
                    m_lfsr = SEED;
                    return;
                end
            end
        end
        check("run_cycles", 64'(cyc), 64'(NV * VC));
        check("run_done_busy", 64'({done, busy}), 64'(2'b10));
        check("run_correct", 64'(correct_cnt), 64'(ec));
        check("run_wrong", 64'(wrong_cnt), 64'(ew));
        check("run_ffail", 64'(first_fail_idx), 64'(ef));
        check("run_pass", 64'(pass), 64'(ew == 0));
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start0     = 1'b0;
        fault_sub  = 1'b0;
        zero_stuck = 1'b0;
        m_lfsr     = SEED;

        repeat (3) @(negedge clk);
        check("reset_status", 64'({busy, done, pass}), 64'(0));
        check("reset_vec", 64'({a_o, b_o, alu_ctrl_o}), 64'(0));
        check("reset_counts", 64'({correct_cnt, wrong_cnt}), 64'(0));
        check("reset_ffail", 64'(first_fail_idx), 64'(16'hFFFF));
        rst_n = 1'b1;

        // Run 3: zero seed is replaced by 1
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("seed0_busy", 64'(busy0), 64'(1'b1));
        @(negedge clk);
        check("seed0_vector", 64'({a0, b0, c0}), 64'({8'h01, 8'h00, 4'h0}));

        // Run 1: correct ALU
        pulse_start();
        run(-1, -1, -1);
        check("run1_correct", 64'(correct_cnt), 64'(NV));
        check("run1_pass", 64'({pass, wrong_cnt}), 64'({1'b1, 16'd0}));
        repeat (4) @(negedge clk);
        check("done_held", 64'(done), 64'(1'b1));

        // Run 2: SUB returns a+b
        fault_sub = 1'b1;
        pulse_start();
        run(-1, -1, -1);
        check("run2_pass", 64'(pass), 64'(1'b0));
        check("run2_total", 64'(correct_cnt + wrong_cnt), 64'(NV));
        fault_sub = 1'b0;

        // Run 4: start while busy is ignored
        pulse_start();
        run(10, 500, -1);
        check("run4_correct", 64'(correct_cnt), 64'(NV));

        // Run 5: reset mid-run, then a full run from the reseeded stream
        pulse_start();
        run(-1, -1, 500);
        pulse_start();
        run(-1, -1, -1);
        check("run5_correct", 64'(correct_cnt), 64'(NV));

        // Run 6: zero flag stuck at 0
        zero_stuck = 1'b1;
        pulse_start();
        run(-1, -1, -1);
`ifndef ALU_BIST_ZERO_CHK_EN
        check("run6_pass_nochk", 64'({pass, wrong_cnt}), 64'({1'b1, 16'd0}));
`endif
        zero_stuck = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
